// File: rtl/drum_mul_pipe.sv
// drum_mul_pipe: three-stage pipelined DRUM approximate multiplier.
//   Each operand is reduced to its magnitude, then truncated to a K-bit mantissa
//   (leading one kept, LSB forced to 1 to centre the truncation error) plus a
//   shift amount. The mantissas are multiplied, shifted back and re-signed.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake for a, b, sign_mode
//   a, b                  N-bit operands
//   sign_mode             0: unsigned operands, 1: two's complement operands
//   out_valid / out_ready result handshake for r
//   r                     2N-bit approximate product
module drum_mul_pipe #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sign_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] r
);

  // Wide enough for the summed shift of both operands.
  localparam int unsigned SW = $clog2(2 * (N - K) + 1);

  // Leading-one detect and DRUM truncation of one magnitude.
  function automatic void f_drum(input  logic [N-1:0]  mag,
                                 output logic [K-1:0]  mant,
                                 output logic [SW-1:0] sh);
    int unsigned p;
    logic [N-1:0] t;
    p = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mag[i]) p = i;
    end
    if (p >= K) begin
      // Bit K-1 of t is the leading one; lower bits are the kept fraction.
      t       = mag >> (p - K + 1);
      mant    = t[K-1:0];
      mant[0] = 1'b1;
      sh      = SW'(p - K + 1);
    end else begin
      t    = '0;
      mant = mag[K-1:0];
      sh   = '0;
    end
  endfunction

  logic w_adv;

  // Stage 1 state
  logic           r_v1;
  logic [K-1:0]   r_mant_a, r_mant_b;
  logic [SW-1:0]  r_sh_a, r_sh_b;
  logic           r_neg1;
  // Stage 2 state
  logic           r_v2;
  logic [2*K-1:0] r_prod;
  logic [SW-1:0]  r_shs;
  logic           r_neg2;
  // Stage 3 state
  logic           r_v3;
  logic [2*N-1:0] r_res;

  logic [N-1:0]   w_mag_a, w_mag_b;
  logic [K-1:0]   w_mant_a, w_mant_b;
  logic [SW-1:0]  w_sh_a, w_sh_b;
  logic           w_neg;
  logic [2*K-1:0] w_prod;
  logic [SW-1:0]  w_shs;
  logic [2*N-1:0] w_mag_r, w_res;

  // Whole pipeline moves as one unit; stalls only when the output is held.
  assign w_adv     = ~r_v3 | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign r         = r_res;

  always_comb begin
    w_mant_a = '0;
    w_mant_b = '0;
    w_sh_a   = '0;
    w_sh_b   = '0;
    // -2^(N-1) negates to itself, which reads correctly as unsigned.
    w_mag_a  = (sign_mode & a[N-1]) ? -a : a;
    w_mag_b  = (sign_mode & b[N-1]) ? -b : b;
    w_neg    = sign_mode & (a[N-1] ^ b[N-1]);
    f_drum(w_mag_a, w_mant_a, w_sh_a);
    f_drum(w_mag_b, w_mant_b, w_sh_b);
  end

  always_comb begin
    w_prod  = {{K{1'b0}}, r_mant_a} * {{K{1'b0}}, r_mant_b};
    w_shs   = r_sh_a + r_sh_b;
    // Product of two K-bit mantissas shifted by at most 2(N-K) fits in 2N bits.
    w_mag_r = {{(2 * N - 2 * K){1'b0}}, r_prod} << r_shs;
    // A zero operand yields a zero product, so negation stays zero.
    w_res   = r_neg2 ? -w_mag_r : w_mag_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_mant_a <= '0;
      r_mant_b <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_neg1   <= 1'b0;
      r_v2     <= 1'b0;
      r_prod   <= '0;
      r_shs    <= '0;
      r_neg2   <= 1'b0;
      r_v3     <= 1'b0;
      r_res    <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      // Data registers load only for real transactions, so r holds through bubbles.
      if (in_valid) begin
        r_mant_a <= w_mant_a;
        r_mant_b <= w_mant_b;
        r_sh_a   <= w_sh_a;
        r_sh_b   <= w_sh_b;
        r_neg1   <= w_neg;
      end
      if (r_v1) begin
        r_prod <= w_prod;
        r_shs  <= w_shs;
        r_neg2 <= r_neg1;
      end
      if (r_v2) begin
        r_res <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_drum_mul_pipe.sv
// tb_drum_mul_pipe: directed checks of drum_mul_pipe (N=16, K=7) covering reset,
// exact and truncated paths, signed mode, backpressure and mid-flight reset.
module tb_drum_mul_pipe;

  localparam int unsigned N = 16;
  localparam int unsigned K = 7;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           sign_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] r;

  int n_tests;
  int n_fail;

  drum_mul_pipe #(.N(N), .K(K)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sign_mode (sign_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one transaction, then wait (bounded) for its result.
  task automatic single(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic sm, input logic [2*N-1:0] exp);
    int lat;
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    sign_mode = sm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_r"}, 64'(r), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]   sa [8];
  logic           ssm[8];
  logic [2*N-1:0] sexp[8];

  initial begin
    int sent;
    int rcv;
    int cyc;
    int stray;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sign_mode = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    single("u_exact", 16'd100, 16'd50, 1'b0, 32'h0000_1388);
    single("u_trunc", 16'd255, 16'd3, 1'b0, 32'h0000_02FA);
    single("u_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFC04_0000);
    single("u_zero", 16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000);
    single("s_neg", 16'hFF9C, 16'd50, 1'b1, 32'hFFFF_EC78);
    // 0x8000 -> mant 65 (LSB forced), sh 9: -(65<<9) = -33280.
    single("s_min", 16'h8000, 16'h0001, 1'b1, 32'hFFFF_7E00);
    // (-2^15)^2 -> 65*65 << 18 = 0x42040000, positive.
    single("s_minsq", 16'h8000, 16'h8000, 1'b1, 32'h4204_0000);
    single("s_m1m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    single("s_zero", 16'h0000, 16'h8000, 1'b1, 32'h0000_0000);

    // Streaming with mixed modes and a 4-cycle output stall.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        sa[i]   = 16'(0) - 16'(10 * (i + 1));
        ssm[i]  = 1'b1;
        sexp[i] = 32'(0) - 32'(30 * (i + 1));
      end else begin
        sa[i]   = 16'(10 * (i + 1));
        ssm[i]  = (i % 4 == 2);
        sexp[i] = 32'(30 * (i + 1));
      end
    end
    sent = 0;
    rcv  = 0;
    cyc  = 0;
    while (rcv < 8 && cyc < 60) begin
      in_valid  = (sent < 8);
      a         = (sent < 8) ? sa[sent] : '0;
      b         = 16'd3;
      sign_mode = (sent < 8) ? ssm[sent] : 1'b0;
      out_ready = !(cyc >= 5 && cyc < 9);
      @(negedge clk);
      if (out_valid) check("strm_r", 64'(r), 64'(sexp[rcv]));
      if (out_valid && !out_ready) check("strm_stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) rcv++;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("strm_sent", 64'(sent), 64'd8);
    check("strm_rcvd", 64'(rcv), 64'd8);
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("strm_no_dup", 64'(stray), 64'd0);
    @(posedge clk);
    #1;

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      a         = 16'(i + 1);
      b         = 16'd7;
      sign_mode = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("inflt_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_r", 64'(r), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("arst_no_stale", 64'(stray), 64'd0);
    @(posedge clk);
    #1;
    single("post_rst", 16'd12, 16'd11, 1'b0, 32'd132);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
